stall_fwd_ctrl: RTL and testbench

Pipeline interlock controller for the five-stage MIPS core. It takes the per-instruction Tuse/Tnew decode of the instruction in D and keeps its own shadow pipeline of destination register and remaining Tnew for E, M and W. From that state it produces the D-stage stall, the D- and E-stage forwarding selects, and the multiply/divide busy interlock. It sits beside the D/E pipeline registers and drives their enable/clear controls.

---
 rtl/stall_fwd_ctrl_if.sv | 32 +++
 rtl/stall_fwd_ctrl.sv | 127 ++++++++++++
 tb/tb_stall_fwd_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stall_fwd_ctrl_if.sv
// Decode-stage bundle between the core pipeline and the interlock controller.
// The pipeline drives the D/E decode fields; the controller returns stall, forwarding selects and MD busy.
interface stall_fwd_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_wa;
  logic [1:0] d_tnew;
  logic       d_md_use;
  logic       e_md_start;
  logic       e_md_div;

  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md_use,
           e_md_start, e_md_div,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md_use,
           e_md_start, e_md_div,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );
endinterface

// File: rtl/stall_fwd_ctrl.sv
// Tuse/Tnew interlock for the five-stage core: shadow E/M/W pipeline of {wa, tnew},
// D-stage stall, D/E forwarding selects and the multiply/divide busy window.
module stall_fwd_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset,
  stall_fwd_ctrl_if.slave bus
);

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } shadow_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  shadow_t    e_q;
  shadow_t    m_q;
  shadow_t    w_q;
  logic [4:0] e_rs_q;
  logic [4:0] e_rt_q;
  logic [3:0] md_cnt_q;

  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;
  logic       stall;
  logic       md_busy;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // tuse = 3 can never be exceeded by a 2-bit tnew, so unused operands drop out here.
  function automatic logic hazard(input logic [4:0] a, input logic [1:0] tuse,
                                  input shadow_t e, input shadow_t m);
    return (a != 5'd0) &&
           (((e.wa == a) && (e.tnew > tuse)) || ((m.wa == a) && (m.tnew > tuse)));
  endfunction

  function automatic logic [1:0] d_sel(input logic [4:0] a, input shadow_t e,
                                       input shadow_t m, input shadow_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (a != 5'd0) begin
      if ((e.wa == a) && (e.tnew == 2'd0))      sel = 2'd1;
      else if ((m.wa == a) && (m.tnew == 2'd0)) sel = 2'd2;
      else if (w.wa == a)                       sel = 2'd3;
    end
    return sel;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] r, input shadow_t m,
                                       input shadow_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (r != 5'd0) begin
      if ((m.wa == r) && (m.tnew == 2'd0)) sel = 2'd1;
      else if (w.wa == r)                  sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    md_busy  = bus.e_md_start || (md_cnt_q != 4'd0);
    stall_rs = hazard(bus.d_rs, bus.d_tuse_rs, e_q, m_q);
    stall_rt = hazard(bus.d_rt, bus.d_tuse_rt, e_q, m_q);
    stall_md = bus.d_md_use && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
    fwd_d_rs = d_sel(bus.d_rs, e_q, m_q, w_q);
    fwd_d_rt = d_sel(bus.d_rt, e_q, m_q, w_q);
    fwd_e_rs = e_sel(e_rs_q, m_q, w_q);
    fwd_e_rt = e_sel(e_rt_q, m_q, w_q);
  end

  // M and W always advance; E takes the D instruction or a bubble on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      e_rs_q <= 5'd0;
      e_rt_q <= 5'd0;
    end else begin
      m_q.wa   <= e_q.wa;
      m_q.tnew <= sat_dec(e_q.tnew);
      w_q.wa   <= m_q.wa;
      w_q.tnew <= sat_dec(m_q.tnew);
      if (stall) begin
        e_q    <= '0;
        e_rs_q <= 5'd0;
        e_rt_q <= 5'd0;
      end else begin
        e_q.wa   <= bus.d_wa;
        e_q.tnew <= bus.d_tnew;
        e_rs_q   <= bus.d_rs;
        e_rt_q   <= bus.d_rt;
      end
    end
  end

  // A new start reloads rather than accumulates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q <= 4'd0;
    end else if (bus.e_md_start) begin
      md_cnt_q <= bus.e_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_q <= md_cnt_q - 4'd1;
    end
  end

  assign bus.stall    = stall;
  assign bus.md_busy  = md_busy;
  assign bus.fwd_d_rs = fwd_d_rs;
  assign bus.fwd_d_rt = fwd_d_rt;
  assign bus.fwd_e_rs = fwd_e_rs;
  assign bus.fwd_e_rt = fwd_e_rt;

endmodule

// File: tb/tb_stall_fwd_ctrl.sv
// Bench for stall_fwd_ctrl: directed scenarios with literal expectations, then random
// decode traffic checked every cycle against an age-based model of in-flight instructions.
module tb_stall_fwd_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  stall_fwd_ctrl_if bus ();

  stall_fwd_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: index = age in cycles since E entry (0 = E, 1 = M, 2 = W); tnew held as issued.
  logic [4:0] m_wa   [3];
  logic [1:0] m_tnew [3];
  logic [4:0] m_rs   [3];
  logic [4:0] m_rt   [3];
  int         m_cyc      = 0;
  int         m_md_last  = 0;
  int         m_md_len   = 0;
  bit         m_md_valid = 1'b0;

  function automatic int rem(input int k);
    return (int'(m_tnew[k]) > k) ? int'(m_tnew[k]) - k : 0;
  endfunction

  function automatic bit mdl_hazard(input logic [4:0] a, input logic [1:0] tuse);
    if (a == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (m_wa[k] == a && rem(k) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mdl_busy();
    return bus.e_md_start ||
           (m_md_valid && (m_cyc - m_md_last) >= 1 && (m_cyc - m_md_last) <= m_md_len);
  endfunction

  function automatic bit mdl_stall();
    return mdl_hazard(bus.d_rs, bus.d_tuse_rs) || mdl_hazard(bus.d_rt, bus.d_tuse_rt) ||
           (bus.d_md_use && mdl_busy());
  endfunction

  function automatic int mdl_fwd_d(input logic [4:0] a);
    if (a == 5'd0) return 0;
    for (int k = 0; k < 3; k++)
      if (m_wa[k] == a && (k == 2 || rem(k) == 0)) return k + 1;
    return 0;
  endfunction

  function automatic int mdl_fwd_e(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (m_wa[1] == r && rem(1) == 0) return 1;
    if (m_wa[2] == r) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_wa[k]   <= 5'd0;
        m_tnew[k] <= 2'd0;
        m_rs[k]   <= 5'd0;
        m_rt[k]   <= 5'd0;
      end
      m_md_valid <= 1'b0;
    end else begin
      if (bus.e_md_start) begin
        m_md_last  <= m_cyc;
        m_md_len   <= bus.e_md_div ? DIV_N : MULT_N;
        m_md_valid <= 1'b1;
      end
      for (int k = 1; k < 3; k++) begin
        m_wa[k]   <= m_wa[k-1];
        m_tnew[k] <= m_tnew[k-1];
        m_rs[k]   <= m_rs[k-1];
        m_rt[k]   <= m_rt[k-1];
      end
      if (mdl_stall()) begin
        m_wa[0] <= 5'd0; m_tnew[0] <= 2'd0; m_rs[0] <= 5'd0; m_rt[0] <= 5'd0;
      end else begin
        m_wa[0] <= bus.d_wa; m_tnew[0] <= bus.d_tnew; m_rs[0] <= bus.d_rs; m_rt[0] <= bus.d_rt;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, 2 time units after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("cmp_stall",    int'(bus.stall),    int'(mdl_stall()));
      chk("cmp_md_busy",  int'(bus.md_busy),  int'(mdl_busy()));
      chk("cmp_fwd_d_rs", int'(bus.fwd_d_rs), mdl_fwd_d(bus.d_rs));
      chk("cmp_fwd_d_rt", int'(bus.fwd_d_rt), mdl_fwd_d(bus.d_rt));
      chk("cmp_fwd_e_rs", int'(bus.fwd_e_rs), mdl_fwd_e(m_rs[0]));
      chk("cmp_fwd_e_rt", int'(bus.fwd_e_rt), mdl_fwd_e(m_rt[0]));
    end
  end

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] wa, input logic [1:0] tnew,
                       input bit md_use, input bit md_start, input bit md_div);
    @(negedge clk);
    bus.d_rs = rs; bus.d_rt = rt; bus.d_tuse_rs = tu_rs; bus.d_tuse_rt = tu_rt;
    bus.d_wa = wa; bus.d_tnew = tnew; bus.d_md_use = md_use;
    bus.e_md_start = md_start; bus.e_md_div = md_div;
    #3;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.d_rs = '0; bus.d_rt = '0; bus.d_tuse_rs = 2'd3; bus.d_tuse_rt = 2'd3;
    bus.d_wa = '0; bus.d_tnew = '0; bus.d_md_use = 1'b0;
    bus.e_md_start = 1'b0; bus.e_md_div = 1'b0;

    // Reset state
    nops(1);
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_busy",  int'(bus.md_busy), 0);
    chk("rst_fwd_e", int'(bus.fwd_e_rs), 0);
    rst = 1'b0;

    // Load-use: lw $8 then addu rs=$8
    drive(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("lu_lw_nostall", int'(bus.stall), 0);
    drive(5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall", int'(bus.stall), 1);
    drive(5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("lu_release", int'(bus.stall), 0);
    chk("lu_fwd_d_rs", int'(bus.fwd_d_rs), 0);
    nops(1);
    chk("lu_fwd_e_rs", int'(bus.fwd_e_rs), 2);
    chk("lu_fwd_e_rt", int'(bus.fwd_e_rt), 0);

    // Branch after ALU
    nops(3);
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("br_alu_nostall", int'(bus.stall), 0);
    drive(5'd3, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("br_stall", int'(bus.stall), 1);
    drive(5'd3, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("br_release", int'(bus.stall), 0);
    chk("br_fwd_d_rs", int'(bus.fwd_d_rs), 2);
    chk("br_fwd_d_rt", int'(bus.fwd_d_rt), 0);

    // $0 writer
    nops(3);
    drive(5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 2'd0, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("r0_stall", int'(bus.stall), 0);
    chk("r0_fwd_d_rs", int'(bus.fwd_d_rs), 0);

    // Div busy with mflo waiting in D
    nops(3);
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b1, 1'b1);
    chk("div_busy_0", int'(bus.md_busy), 1);
    chk("div_stall_0", int'(bus.stall), 1);
    for (int i = 1; i <= DIV_N; i++) begin
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      chk("div_busy_n", int'(bus.md_busy), 1);
      chk("div_stall_n", int'(bus.stall), 1);
    end
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("div_end_busy", int'(bus.md_busy), 0);
    chk("div_end_stall", int'(bus.stall), 0);

    // E over M priority on equal wa
    nops(3);
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("prio_fwd_d_rs", int'(bus.fwd_d_rs), 1);
    chk("prio_stall", int'(bus.stall), 0);

    // Reset mid-div with a register hazard also pending
    nops(3);
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    nops(2);
    drive(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    drive(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("mid_busy_pre", int'(bus.md_busy), 1);
    chk("mid_stall_pre", int'(bus.stall), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_busy_rst", int'(bus.md_busy), 0);
    chk("mid_stall_rst", int'(bus.stall), 0);
    chk("mid_fwd_d_rs", int'(bus.fwd_d_rs), 0);
    chk("mid_fwd_e_rs", int'(bus.fwd_e_rs), 0);
    @(negedge clk);
    #4 rst = 1'b0;

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus.d_rs       = 5'($urandom_range(0, 3));
      bus.d_rt       = 5'($urandom_range(0, 3));
      bus.d_tuse_rs  = 2'($urandom_range(0, 3));
      bus.d_tuse_rt  = 2'($urandom_range(0, 3));
      bus.d_wa       = 5'($urandom_range(0, 3));
      bus.d_tnew     = 2'($urandom_range(0, 3));
      bus.d_md_use   = ($urandom_range(0, 3) == 0);
      bus.e_md_start = ($urandom_range(0, 11) == 0);
      bus.e_md_div   = $urandom_range(0, 1) == 1;
      if (rst) begin
        #4 rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        #4 rst = 1'b1;
      end
    end

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
